ext_ram_bridge: RTL
===================

# ext_ram_bridge

Sequencing bridge between the Neander-X `cpu_top` memory port and the TinyTapeout pins that drive the external 32-byte SRAM. It turns the CPU's level `mem_read`/`mem_write` requests into timed SRAM cycles: address setup, OE/WE pulse width, data hold and bus turnaround. It drives the shared 8-bit data bus direction and captures read data into a holding register. A `mem_ready` pulse tells the CPU when the access has completed.

## Interface
Parameters:
- `ADDR_BITS`, 5: SRAM address width; CPU address bits above this are ignored (aliasing).
- `READ_WAIT`, 1: extra OE-active cycles before read capture (0..7).
- `WRITE_WAIT`, 1: extra WE-active cycles (0..7).

Ports:
- `clk`  in  1: single clock for all logic.
- `reset`  in  1: asynchronous, active-high reset.
- `mem_addr`  in  8: CPU address.
- `mem_data_out`  in  8: CPU write data.
- `mem_read`  in  1: CPU read request, level; held until `mem_ready`.
- `mem_write`  in  1: CPU write request, level; held until `mem_ready`.
- `mem_rdata`  out  8: last captured read data; held until the next read capture.
- `mem_ready`  out  1: one-cycle completion pulse.
- `busy`  out  1: high in every state except IDLE.
- `ram_addr`  out  ADDR_BITS: SRAM address.
- `ram_we`  out  1: SRAM write enable, active high.
- `ram_oe`  out  1: SRAM output enable, active high.
- `ram_dout`  out  8: data driven onto the bus.
- `ram_doe`  out  8: per-bit bus drive enable; all bits equal.
- `ram_din`  in  8: bus input from the SRAM.

## Operation
- States: IDLE, RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Request sampling:
  - Requests are sampled only in IDLE.
  - If both strobes are high, the write wins and the read is dropped.
  - On acceptance, `mem_addr[ADDR_BITS-1:0]` and `mem_data_out` are latched. These latched copies drive the pins for the whole access; CPU input changes mid-access are ignored.
- Read path:
  - IDLE→RD_ACT: `ram_oe`=1 for READ_WAIT+1 cycles, counted by a 3-bit wait counter.
  - On the last RD_ACT edge, `ram_din` is registered into `mem_rdata`. The state then goes to DONE.
- Write path:
  - IDLE→WR_SETUP (1 cycle): address and data driven, `ram_doe`=8'hFF, `ram_we`=0.
  - WR_PULSE: `ram_we`=1 for WRITE_WAIT+1 cycles.
  - WR_HOLD (1 cycle): `ram_we`=0, data still driven.
  - Then DONE.
- DONE (1 cycle): `mem_ready`=1, `ram_doe`=0, `ram_we`=`ram_oe`=0. Always returns to IDLE.
- `ram_doe` is nonzero only in WR_SETUP/WR_PULSE/WR_HOLD. `ram_oe` and `ram_doe` are never both active. A read following a write therefore gets at least 2 bus-idle cycles (DONE, IDLE).
- CPU handshake: the CPU must drop its strobe in the IDLE cycle after `mem_ready`. If the strobe is still high there, a new access of the same type starts.
- `ram_addr` holds the last latched address in IDLE; it does not return to 0.
- All outputs are registered; no combinational path from CPU inputs to pins.

## Timing
- Request first seen high in IDLE during cycle 0.
- Read: `ram_oe` high in cycles 1..READ_WAIT+1; `mem_ready` and new `mem_rdata` valid in cycle READ_WAIT+2 (cycle 3 at default).
- Write: setup in cycle 1; `ram_we` high in cycles 2..WRITE_WAIT+2; hold in cycle WRITE_WAIT+3; `mem_ready` in cycle WRITE_WAIT+4 (cycle 5 at default).
- Minimum back-to-back spacing: one IDLE cycle between DONE and the next access.
- Reset values:
  - state IDLE.
  - `ram_we`=`ram_oe`=0, `ram_doe`=0.
  - `mem_ready`=0, `busy`=0.
  - `mem_rdata`=0, `ram_addr`=0, `ram_dout`=0.
  - wait counter 0.
- Reset mid-access takes effect asynchronously: WE/OE/DOE drop immediately and no `mem_ready` is issued. The aborted write may be partial in the SRAM.

## Structure
- `neander_pkg`: `bridge_state_t` enum and `DEFAULT_READ_WAIT`/`DEFAULT_WRITE_WAIT` constants.
- Single module; no sub-module. The wait counter is inline.
- The top level replaces its direct `uio_oe`/`uo_out` assignments with this block's pin outputs.
- `cpu_top` gains a `mem_ready` stall input.

## Test plan
- Read at default params: addr 8'h25, `ram_din`=8'hA7 → `ram_addr`=5'h05, `ram_oe` high cycles 1-2, `mem_ready` cycle 3, `mem_rdata`=8'hA7.
- Write addr 8'h1F, data 8'h3C → `ram_doe`=8'hFF cycles 1-4, `ram_we` cycles 2-3, `ram_dout`=8'h3C, `mem_ready` cycle 5.
- Both strobes high → write cycle only, `ram_oe` never asserted, `mem_rdata` unchanged.
- Write immediately followed by read → `ram_doe`=0 for at least 2 cycles before `ram_oe` rises; never overlapping.
- Reset asserted in WR_PULSE → `ram_we`, `ram_doe`, `busy` zero in the same cycle, no `mem_ready`, IDLE after release.
- READ_WAIT=3, WRITE_WAIT=0 → read `mem_ready` cycle 5; write `ram_we` one cycle (cycle 2), `mem_ready` cycle 4.

Source files
------------

// File: rtl/neander_pkg.sv
// Shared types and defaults for the Neander-X external SRAM bridge.
package neander_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ACT   = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } bridge_state_t;

  localparam int DEFAULT_READ_WAIT  = 1;
  localparam int DEFAULT_WRITE_WAIT = 1;

endpackage

// File: rtl/ext_ram_bridge.sv
// Sequences CPU level read/write requests into timed SRAM cycles with
// registered pin outputs and a one-cycle mem_ready completion pulse.
module ext_ram_bridge
  import neander_pkg::*;
#(
  parameter int ADDR_BITS  = 5,
  parameter int READ_WAIT  = DEFAULT_READ_WAIT,
  parameter int WRITE_WAIT = DEFAULT_WRITE_WAIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           mem_addr,
  input  logic [7:0]           mem_data_out,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic [7:0]           mem_rdata,
  output logic                 mem_ready,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic                 ram_oe,
  output logic [7:0]           ram_dout,
  output logic [7:0]           ram_doe,
  input  logic [7:0]           ram_din
);

  localparam logic [2:0] RD_WAIT_INIT = 3'(READ_WAIT);
  localparam logic [2:0] WR_WAIT_INIT = 3'(WRITE_WAIT);

  bridge_state_t        state_q, state_d;
  logic [2:0]           wait_q, wait_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 ram_we_q, ram_we_d;
  logic                 ram_oe_q, ram_oe_d;
  logic [7:0]           ram_doe_q, ram_doe_d;
  logic                 mem_ready_q, mem_ready_d;
  logic                 busy_q, busy_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        // A simultaneous read and write request services only the write.
        if (mem_write || mem_read) begin
          addr_d  = mem_addr[ADDR_BITS-1:0];
          wdata_d = mem_data_out;
          if (mem_write) begin
            state_d = ST_WR_SETUP;
          end else begin
            state_d = ST_RD_ACT;
            wait_d  = RD_WAIT_INIT;
          end
        end
      end
      ST_RD_ACT: begin
        if (wait_q == 3'd0) begin
          rdata_d = ram_din;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        wait_d  = WR_WAIT_INIT;
      end
      ST_WR_PULSE: begin
        if (wait_q == 3'd0) begin
          state_d = ST_WR_HOLD;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_WR_HOLD: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Pin controls are decoded from the next state so they leave the block straight from flops.
  always_comb begin
    ram_oe_d    = (state_d == ST_RD_ACT);
    ram_we_d    = (state_d == ST_WR_PULSE);
    ram_doe_d   = {8{(state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                     (state_d == ST_WR_HOLD)}};
    mem_ready_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_doe_q   <= '0;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ram_we_q    <= ram_we_d;
      ram_oe_q    <= ram_oe_d;
      ram_doe_q   <= ram_doe_d;
      mem_ready_q <= mem_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_dout  = wdata_q;
  assign mem_rdata = rdata_q;
  assign ram_we    = ram_we_q;
  assign ram_oe    = ram_oe_q;
  assign ram_doe   = ram_doe_q;
  assign mem_ready = mem_ready_q;
  assign busy      = busy_q;

endmodule
